// File: rtl/ex_mem_stage_pkg.sv
// ============================================================================
// ex_mem_stage_pkg : shared CPU encodings (branch types, cond codes, NZVC bits)
// Rev 1.0
// ============================================================================
`default_nettype none

package ex_mem_stage_pkg;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_COND = 2'b01,
    BR_CBZ  = 2'b10,
    BR_CBNZ = 2'b11
  } br_type_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_HS = 4'h2, COND_LO = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  // Bit positions inside the {N,Z,V,C} flag register
  localparam int C_FLAG_N = 3;
  localparam int C_FLAG_Z = 2;
  localparam int C_FLAG_V = 1;
  localparam int C_FLAG_C = 0;

  localparam logic [3:0] C_ALU_AND    = 4'b0000;
  localparam logic [3:0] C_ALU_ORR    = 4'b0001;
  localparam logic [3:0] C_ALU_ADD    = 4'b0010;
  localparam logic [3:0] C_ALU_SUB    = 4'b0110;
  localparam logic [3:0] C_ALU_PASS_B = 4'b0111;

endpackage

`default_nettype wire

// File: rtl/ex_mem_stage_if.sv
// ============================================================================
// ex_mem_stage_if : EX-side inputs and MEM-side view of the EX/MEM register
// Rev 1.0
// ============================================================================
`default_nettype none

interface ex_mem_stage_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             stall;
  logic             flush;
  logic [WIDTH-1:0] alu_result;
  logic             alu_negative;
  logic             alu_zero;
  logic             alu_overflow;
  logic             alu_carry_out;
  logic             set_flags;
  logic [1:0]       br_type;
  logic [3:0]       cond;
  logic [4:0]       rd;
  logic             reg_write;
  logic             mem_read;
  logic             mem_write;
  logic [WIDTH-1:0] store_data;

  logic             out_valid;
  logic [WIDTH-1:0] out_result;
  logic [4:0]       out_rd;
  logic             out_reg_write;
  logic             out_mem_read;
  logic             out_mem_write;
  logic [WIDTH-1:0] out_store_data;
  logic [3:0]       flags_nzvc;
  logic             br_taken;

  modport master (
    output in_valid, stall, flush, alu_result, alu_negative, alu_zero,
           alu_overflow, alu_carry_out, set_flags, br_type, cond, rd,
           reg_write, mem_read, mem_write, store_data,
    input  out_valid, out_result, out_rd, out_reg_write, out_mem_read,
           out_mem_write, out_store_data, flags_nzvc, br_taken
  );

  modport slave (
    input  in_valid, stall, flush, alu_result, alu_negative, alu_zero,
           alu_overflow, alu_carry_out, set_flags, br_type, cond, rd,
           reg_write, mem_read, mem_write, store_data,
    output out_valid, out_result, out_rd, out_reg_write, out_mem_read,
           out_mem_write, out_store_data, flags_nzvc, br_taken
  );

endinterface

`default_nettype wire

// File: rtl/ex_mem_stage_cond_eval.sv
// ============================================================================
// cond_eval : combinational LEGv8 condition-code check against NZVC flags
// Rev 1.0
// ============================================================================
`default_nettype none

module cond_eval
  import ex_mem_stage_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzvc,
  output logic       pass
);

  logic w_n, w_z, w_v, w_c;

  assign w_n = nzvc[C_FLAG_N];
  assign w_z = nzvc[C_FLAG_Z];
  assign w_v = nzvc[C_FLAG_V];
  assign w_c = nzvc[C_FLAG_C];

  always_comb begin
    pass = 1'b1;
    unique case (cond_e'(cond))
      COND_EQ: pass = w_z;
      COND_NE: pass = !w_z;
      COND_HS: pass = w_c;
      COND_LO: pass = !w_c;
      COND_MI: pass = w_n;
      COND_PL: pass = !w_n;
      COND_VS: pass = w_v;
      COND_VC: pass = !w_v;
      COND_HI: pass = w_c & !w_z;
      COND_LS: pass = !(w_c & !w_z);
      COND_GE: pass = (w_n == w_v);
      COND_LT: pass = (w_n != w_v);
      COND_GT: pass = !w_z & (w_n == w_v);
      COND_LE: pass = !(!w_z & (w_n == w_v));
      default: pass = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ex_mem_stage.sv
// ============================================================================
// ex_mem_stage : EX/MEM pipeline register with NZVC flag register and branch resolve
// Rev 1.0
// ============================================================================
`default_nettype none

module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic          clk,
  input  logic          reset,
  ex_mem_stage_if.slave bus
);

  logic             r_valid;
  logic             r_reg_write;
  logic             r_mem_read;
  logic             r_mem_write;
  logic             r_br_taken;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_store_data;
  logic [4:0]       r_rd;
  logic [3:0]       r_flags;

  logic             w_cond_pass;
  logic             w_br_decide;

  // B.cond looks at the committed flags, not this cycle's ALU flags
  cond_eval u_cond_eval (
    .cond (bus.cond),
    .nzvc (r_flags),
    .pass (w_cond_pass)
  );

  always_comb begin
    w_br_decide = 1'b0;
    unique case (br_type_e'(bus.br_type))
      BR_NONE: w_br_decide = 1'b0;
      BR_COND: w_br_decide = w_cond_pass;
      BR_CBZ:  w_br_decide = bus.alu_zero;
      BR_CBNZ: w_br_decide = !bus.alu_zero;
      default: w_br_decide = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_br_taken   <= 1'b0;
      r_result     <= '0;
      r_store_data <= '0;
      r_rd         <= '0;
      r_flags      <= '0;
    end else if (bus.flush) begin
      // Flush wins over stall; data fields keep their stale values
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_br_taken  <= 1'b0;
    end else if (!bus.stall) begin
      r_valid      <= bus.in_valid;
      r_reg_write  <= bus.in_valid & bus.reg_write;
      r_mem_read   <= bus.in_valid & bus.mem_read;
      r_mem_write  <= bus.in_valid & bus.mem_write;
      r_br_taken   <= bus.in_valid & w_br_decide;
      r_result     <= bus.alu_result;
      r_store_data <= bus.store_data;
      r_rd         <= bus.rd;
      if (bus.in_valid && bus.set_flags) begin
        r_flags[C_FLAG_N] <= bus.alu_negative;
        r_flags[C_FLAG_Z] <= bus.alu_zero;
        r_flags[C_FLAG_V] <= bus.alu_overflow;
        r_flags[C_FLAG_C] <= bus.alu_carry_out;
      end
    end
  end

  assign bus.out_valid      = r_valid;
  assign bus.out_result     = r_result;
  assign bus.out_rd         = r_rd;
  assign bus.out_reg_write  = r_reg_write;
  assign bus.out_mem_read   = r_mem_read;
  assign bus.out_mem_write  = r_mem_write;
  assign bus.out_store_data = r_store_data;
  assign bus.flags_nzvc     = r_flags;
  assign bus.br_taken       = r_br_taken;

endmodule

`default_nettype wire
